// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and
// the clocks-per-bit helper also used by the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int DATA_BITS = 8;

    function automatic int bps_cnt(input int clk, input int bps);
        return clk / bps;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input with a registered
// falling-edge pulse; resets to the idle-high level.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic d0_q, d0_d;
    logic d1_q, d1_d;
    logic d2_q, d2_d;
    logic fall_q, fall_d;

    always_comb begin
        d0_d   = din;
        d1_d   = d0_q;
        d2_d   = d1_q;
        fall_d = d2_q & ~d1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d0_q   <= 1'b1;
            d1_q   <= 1'b1;
            d2_q   <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            d0_q   <= d0_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            fall_q <= fall_d;
        end
    end

    assign dout = d1_q;
    assign fall = fall_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection,
// stop-bit check with one-cycle done / framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FRE = 50_000_000,
    parameter int BPS         = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BPS_CNT = bps_cnt(SYS_CLK_FRE, BPS);
    localparam logic [15:0] HALF_END = 16'(BPS_CNT / 2 - 1);
    localparam logic [15:0] BIT_END = 16'(BPS_CNT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_sync;
    logic rx_fall;

    rx_state_e            state_q, state_d;
    logic [15:0]          clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;

    uart_sync u_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (uart_rxd),
        .dout (rx_sync),
        .fall (rx_fall)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (rx_fall) state_d = START;
            end
            START: begin
                if (clk_cnt_q == HALF_END) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is caught
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    if (rx_sync) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign uart_data = data_q;
    assign uart_done = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 frames at the nominal
// bit time and compares pulses, latency and data to expected values.
module tb_uart_rx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115200;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int LAT    = 3 + BIT / 2 + 9 * BIT;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int both   = 0;
    int unsigned cyc = 0;
    int unsigned done_cyc[$];
    logic [7:0]  done_dat[$];
    int unsigned ferr_cyc[$];
    logic [7:0]  last_good = 8'h00;

    uart_rx #(.SYS_CLK_FRE(CLK_HZ), .BPS(BAUD)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_rxd  (uart_rxd),
        .uart_data (uart_data),
        .uart_done (uart_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (uart_done) begin
            done_cyc.push_back(cyc);
            done_dat.push_back(uart_data);
        end
        if (frame_err) ferr_cyc.push_back(cyc);
        if (uart_done && frame_err) both++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clear_events();
        done_cyc.delete();
        done_dat.delete();
        ferr_cyc.delete();
    endtask

    // Called at a negedge; the transmitter shares sys_rst, so a reset
    // mid-frame also returns the line to idle.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit,
                               input int rst_bit, output int unsigned st);
        logic [9:0] lv;
        lv = {stop_bit, b, 1'b0};
        st = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            uart_rxd = lv[k];
            for (int c = 0; c < BIT; c++) begin
                if (k == rst_bit && c == BIT / 2) begin
                    sys_rst  = 1'b1;
                    uart_rxd = 1'b1;
                end
                @(negedge sys_clk);
                if (sys_rst) begin
                    sys_rst = 1'b0;
                    return;
                end
            end
        end
        uart_rxd = 1'b1;
    endtask

    task automatic expect_one_done(input string name, input logic [7:0] b,
                                   input int unsigned st);
        checks++;
        if (done_cyc.size() != 1) begin
            errors++;
            $display("FAIL %s done_count got %0d want 1", name, done_cyc.size());
        end else begin
            checks++;
            if (int'(done_cyc[0] - st) !== LAT) begin
                errors++;
                $display("FAIL %s latency got %0d want %0d", name,
                         int'(done_cyc[0] - st), LAT);
            end
            checks++;
            if (done_dat[0] !== b) begin
                errors++;
                $display("FAIL %s pulse_data got %02h want %02h", name, done_dat[0], b);
            end
        end
        checks++;
        if (uart_data !== b) begin
            errors++;
            $display("FAIL %s uart_data got %02h want %02h", name, uart_data, b);
        end
        checks++;
        if (ferr_cyc.size() != 0) begin
            errors++;
            $display("FAIL %s frame_err_count got %0d want 0", name, ferr_cyc.size());
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s rx_busy got %b want 0", name, rx_busy);
        end
    endtask

    task automatic test_reset();
        idle(3);
        sys_rst = 1'b0;
        checks++;
        if ({uart_data, uart_done, frame_err, rx_busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset outputs got %02h/%b/%b/%b want 00/0/0/0",
                     uart_data, uart_done, frame_err, rx_busy);
        end
        clear_events();
        idle(10000);
        checks++;
        if (done_cyc.size() + ferr_cyc.size() != 0) begin
            errors++;
            $display("FAIL idle_events got %0d want 0", done_cyc.size() + ferr_cyc.size());
        end
        checks++;
        if (uart_data !== 8'h00 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_state got data %02h busy %b want 00 0", uart_data, rx_busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] vals[3];
        int unsigned st;
        vals[0] = 8'hA5;
        vals[1] = 8'($urandom);
        vals[2] = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            clear_events();
            drive_frame(vals[i], 1'b1, -1, st);
            idle(20);
            expect_one_done("single", vals[i], st);
            last_good = vals[i];
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[4];
        int unsigned st[4];
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        vals[2] = 8'h55;
        vals[3] = 8'($urandom);
        clear_events();
        for (int i = 0; i < 4; i++) drive_frame(vals[i], 1'b1, -1, st[i]);
        idle(20);
        checks++;
        if (done_cyc.size() != 4) begin
            errors++;
            $display("FAIL b2b done_count got %0d want 4", done_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (done_dat[i] !== vals[i] || int'(done_cyc[i] - st[i]) !== LAT) begin
                    errors++;
                    $display("FAIL b2b frame%0d got %02h@%0d want %02h@%0d", i,
                             done_dat[i], int'(done_cyc[i] - st[i]), vals[i], LAT);
                end
            end
        end
        last_good = vals[3];
        checks++;
        if (uart_data !== last_good) begin
            errors++;
            $display("FAIL b2b uart_data got %02h want %02h", uart_data, last_good);
        end
    endtask

    task automatic test_glitch();
        clear_events();
        uart_rxd = 1'b0;
        idle(50);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch busy_rise got %b want 1", rx_busy);
        end
        idle(50);
        uart_rxd = 1'b1;
        idle(400);
        checks++;
        if (rx_busy !== 1'b0 || done_cyc.size() + ferr_cyc.size() != 0) begin
            errors++;
            $display("FAIL glitch rejected got busy %b events %0d want 0 0",
                     rx_busy, done_cyc.size() + ferr_cyc.size());
        end
        checks++;
        if (uart_data !== last_good) begin
            errors++;
            $display("FAIL glitch uart_data got %02h want %02h", uart_data, last_good);
        end
    endtask

    task automatic test_frame_err();
        int unsigned st;
        clear_events();
        drive_frame(8'h3C, 1'b0, -1, st);
        idle(20);
        checks++;
        if (ferr_cyc.size() != 1) begin
            errors++;
            $display("FAIL ferr count got %0d want 1", ferr_cyc.size());
        end else begin
            checks++;
            if (int'(ferr_cyc[0] - st) !== LAT) begin
                errors++;
                $display("FAIL ferr latency got %0d want %0d", int'(ferr_cyc[0] - st), LAT);
            end
        end
        checks++;
        if (done_cyc.size() != 0 || uart_data !== last_good) begin
            errors++;
            $display("FAIL ferr data_kept got %02h done %0d want %02h 0",
                     uart_data, done_cyc.size(), last_good);
        end
        clear_events();
        drive_frame(8'h81, 1'b1, -1, st);
        idle(20);
        expect_one_done("after_ferr", 8'h81, st);
        last_good = 8'h81;
    endtask

    task automatic test_break();
        int unsigned st;
        clear_events();
        uart_rxd = 1'b0;
        st = cyc + 1;
        idle(20 * BIT);
        uart_rxd = 1'b1;
        idle(20);
        checks++;
        if (ferr_cyc.size() != 1 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL break events got ferr %0d done %0d want 1 0",
                     ferr_cyc.size(), done_cyc.size());
        end else begin
            checks++;
            if (int'(ferr_cyc[0] - st) !== LAT) begin
                errors++;
                $display("FAIL break latency got %0d want %0d", int'(ferr_cyc[0] - st), LAT);
            end
        end
        checks++;
        if (uart_data !== last_good) begin
            errors++;
            $display("FAIL break uart_data got %02h want %02h", uart_data, last_good);
        end
    endtask

    task automatic test_mid_reset();
        int unsigned st;
        clear_events();
        drive_frame(8'hC3, 1'b1, 5, st);
        checks++;
        if (uart_data !== 8'h00 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset state got %02h busy %b want 00 0", uart_data, rx_busy);
        end
        last_good = 8'h00;
        idle(10 * BIT);
        checks++;
        if (done_cyc.size() + ferr_cyc.size() != 0) begin
            errors++;
            $display("FAIL mid_reset events got %0d want 0", done_cyc.size() + ferr_cyc.size());
        end
        clear_events();
        drive_frame(8'h7E, 1'b1, -1, st);
        idle(20);
        expect_one_done("after_reset", 8'h7E, st);
        last_good = 8'h7E;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_break();
        test_mid_reset();
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL done_and_ferr_overlap got %0d want 0", both);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
